// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: sample, per-bit DAC trials, result capture.
// Optional macro SAR_ADC_CONT_EN: start acts as a level and conversions repeat while it stays high.
module sar_adc_ctrl #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned SETTLE = 1
) (
   input  logic             clock,
   input  logic             resetb,
   input  logic             start,
   input  logic             cmp,
   output logic             sample,
   output logic [WIDTH-1:0] dac,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] data,
   output logic             q_out
);

   localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned CW = 4;
   localparam logic [IW-1:0] MSB_IDX  = IW'(WIDTH - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE - 1);

   typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_t;

   state_t           state, state_nxt;
   logic             go;
   logic [IW-1:0]    idx, idx_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] code, code_nxt, kept;
   logic [WIDTH-1:0] dac_nxt, data_nxt;
   logic             sample_nxt, busy_nxt, done_nxt, q_nxt;

`ifdef SAR_ADC_CONT_EN
   assign go = start;
`else
   logic start_q, req_q;

   // Registered rising-edge request; only armed while idle so busy/done-time edges are dropped
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         start_q <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         start_q <= start;
         req_q   <= (state == IDLE) && !req_q && start && !start_q;
      end
   end

   assign go = req_q;
`endif

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state  <= IDLE;
         idx    <= '0;
         cnt    <= '0;
         code   <= '0;
         sample <= 1'b0;
         dac    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         data   <= '0;
         q_out  <= 1'b0;
      end else begin
         state  <= state_nxt;
         idx    <= idx_nxt;
         cnt    <= cnt_nxt;
         code   <= code_nxt;
         sample <= sample_nxt;
         dac    <= dac_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
         data   <= data_nxt;
         q_out  <= q_nxt;
      end
   end

   // Next state plus next values of every registered output
   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      cnt_nxt    = cnt;
      code_nxt   = code;
      sample_nxt = 1'b0;
      busy_nxt   = 1'b0;
      done_nxt   = 1'b0;
      dac_nxt    = '0;
      data_nxt   = data;
      q_nxt      = q_out;
      kept       = code | (WIDTH'(cmp) << idx);
      case (state)
         IDLE: begin
            if (go) begin
               state_nxt  = SAMPLE;
               sample_nxt = 1'b1;
               busy_nxt   = 1'b1;
            end
         end
         SAMPLE: begin
            state_nxt = CONV;
            idx_nxt   = MSB_IDX;
            cnt_nxt   = '0;
            code_nxt  = '0;
            busy_nxt  = 1'b1;
            dac_nxt   = WIDTH'(1) << MSB_IDX;
         end
         CONV: begin
            busy_nxt = 1'b1;
            dac_nxt  = dac;
            if (cnt == LAST_CNT) begin
               code_nxt = kept;
               q_nxt    = cmp;
               cnt_nxt  = '0;
               if (idx == '0) begin
                  state_nxt = DONE;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  data_nxt  = kept;
                  dac_nxt   = '0;
               end else begin
                  idx_nxt = idx - IW'(1);
                  dac_nxt = kept | (WIDTH'(1) << (idx - IW'(1)));
               end
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: one SETTLE=1 and one SETTLE=3 instance driven by a vin>=dac comparator model.
module tb_sar_adc_ctrl;

   logic       clock = 1'b0;
   logic       resetb;
   logic       start_a, start_b;
   logic       cmp_a, cmp_b;
   logic [7:0] vin;
   logic       sample_a, busy_a, done_a, q_out_a;
   logic       sample_b, busy_b, done_b, q_out_b;
   logic [7:0] dac_a, data_a, dac_b, data_b;
   logic       sel;
   logic       sample_m, busy_m, done_m, q_m;
   logic [7:0] dac_m, data_m;
   int         total = 0;
   int         bad   = 0;

   always #5 clock = ~clock;

   sar_adc_ctrl #(.WIDTH(8), .SETTLE(1)) u_a (
      .clock(clock), .resetb(resetb), .start(start_a), .cmp(cmp_a),
      .sample(sample_a), .dac(dac_a), .busy(busy_a), .done(done_a),
      .data(data_a), .q_out(q_out_a));

   sar_adc_ctrl #(.WIDTH(8), .SETTLE(3)) u_b (
      .clock(clock), .resetb(resetb), .start(start_b), .cmp(cmp_b),
      .sample(sample_b), .dac(dac_b), .busy(busy_b), .done(done_b),
      .data(data_b), .q_out(q_out_b));

   assign cmp_a    = (vin >= dac_a);
   assign cmp_b    = (vin >= dac_b);
   assign sample_m = sel ? sample_b : sample_a;
   assign busy_m   = sel ? busy_b   : busy_a;
   assign done_m   = sel ? done_b   : done_a;
   assign q_m      = sel ? q_out_b  : q_out_a;
   assign dac_m    = sel ? dac_b    : dac_a;
   assign data_m   = sel ? data_b   : data_a;

   typedef struct {
      logic [7:0] vin;
      logic [7:0] exp_data;
      string      name;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel) start_b = v;
      else     start_a = v;
   endtask

   // Trial code for bit 7-j: already-decided upper bits of the result plus the bit under test
   function automatic logic [7:0] trial(input logic [7:0] e, input int j);
      logic [7:0] m;
      logic [7:0] one;
      m   = 8'hFF;
      m   = m << (8 - j);
      one = 8'h80;
      return (e & m) | (one >> j);
   endfunction

   task automatic convert(input int s, input logic [7:0] v, input logic [7:0] exp,
                          input string name, input bit extra);
      logic [7:0] qseq;
      bit         dac_ok;
      bit         got;
      int         lat;
      int         exp_lat;
`ifdef SAR_ADC_CONT_EN
      exp_lat = 8 * s + 1;
`else
      exp_lat = 8 * s + 2;
`endif
      vin    = v;
      sel    = (s == 3);
      qseq   = '0;
      dac_ok = 1'b1;
      got    = 1'b0;
      lat    = 0;
      @(negedge clock);
      set_start(1'b1);
      @(posedge clock);
      #1;
      set_start(1'b0);
      for (int k = 1; k <= 200 && !got; k++) begin
         @(posedge clock);
         #1;
         if (k == 1)
            chk({name, " sample phase"}, {sample_m, busy_m, dac_m}, {1'b1, 1'b1, 8'h00});
         for (int j = 0; j < 8; j++) begin
            if (k == 2 + s * j && dac_m !== trial(exp, j)) dac_ok = 1'b0;
            if (k == 2 + s * (j + 1)) qseq[7-j] = q_m;
         end
         if (extra && k == 5) set_start(1'b1);
         if (extra && k == 6) set_start(1'b0);
         if (done_m) begin
            got = 1'b1;
            lat = k;
            if (extra) set_start(1'b1);
         end
      end
      chk({name, " done seen"}, {31'd0, got}, 32'd1);
      chk({name, " latency"}, lat, exp_lat);
      chk({name, " data"}, data_m, exp);
      chk({name, " q_out seq"}, qseq, exp);
      chk({name, " dac trials"}, {31'd0, dac_ok}, 32'd1);
      chk({name, " done phase"}, {busy_m, sample_m, dac_m}, 10'd0);
      @(posedge clock);
      #1;
      if (extra) set_start(1'b0);
      chk({name, " done one cycle"}, {31'd0, done_m}, 32'd0);
   endtask

   initial begin
      int ndone;
      resetb  = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      vin     = 8'h00;
      sel     = 1'b0;
      vecs[0] = '{8'hFF, 8'hFF, "cmp tied 1"};
      vecs[1] = '{8'h00, 8'h00, "cmp tied 0"};
      vecs[2] = '{8'hA5, 8'hA5, "vin a5"};
      vecs[3] = '{8'h80, 8'h80, "vin 80 equal"};
      vecs[4] = '{8'h7F, 8'h7F, "vin 7f"};
      vecs[5] = '{8'h01, 8'h01, "vin 01"};
      vecs[6] = '{8'hC3, 8'hC3, "vin c3"};

      #12;
      chk("reset outputs", {sample_a, busy_a, done_a, q_out_a, dac_a, data_a}, 32'd0);

      // start already high when reset releases: the first edge must count as a request
      start_a = 1'b1;
      @(posedge clock);
      #1;
      resetb = 1'b1;
      convert(1, 8'hA5, 8'hA5, "start high at reset", 1'b0);

      foreach (vecs[i]) convert(1, vecs[i].vin, vecs[i].exp_data, vecs[i].name, 1'b0);

      // SETTLE=3 with stray start pulses in CONV and in DONE that must not queue
      convert(3, 8'h3C, 8'h3C, "settle3 3c", 1'b1);
      ndone = 0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (done_b) ndone++;
      end
      chk("settle3 no queued conv", ndone, 0);
      chk("settle3 data held", data_b, 8'h3C);

      // reset during the bit-4 trial aborts with everything cleared
      sel   = 1'b0;
      vin   = 8'h5A;
      ndone = 0;
      @(negedge clock);
      start_a = 1'b1;
      @(posedge clock);
      #1;
      start_a = 1'b0;
      repeat (5) begin
         @(posedge clock);
         #1;
         if (done_a) ndone++;
      end
      chk("abort at bit4 trial", dac_a, 8'h50);
      resetb = 1'b0;
      #1;
      chk("abort outputs cleared", {sample_a, busy_a, done_a, q_out_a, dac_a, data_a}, 32'd0);
      repeat (3) begin
         @(posedge clock);
         #1;
         if (done_a) ndone++;
      end
      chk("abort no done", ndone, 0);
      resetb = 1'b1;
      convert(1, 8'h5A, 8'h5A, "after abort", 1'b0);

      // start held high for 50 edges
      ndone = 0;
      @(negedge clock);
      start_a = 1'b1;
      repeat (50) begin
         @(posedge clock);
         #1;
         if (done_a) ndone++;
      end
      start_a = 1'b0;
      repeat (30) begin
         @(posedge clock);
         #1;
         if (done_a) ndone++;
      end
`ifdef SAR_ADC_CONT_EN
      chk("held start done count", ndone, 5);
`else
      chk("held start done count", ndone, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
